// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the 5-stage MIPS pipeline
//                control blocks: memory-wait FSM state encoding, NOP word
//                and default register-address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default width of a register-file address (32 GPRs)
    localparam int MIPS_REG_W = 5;

    // sll $0,$0,0 - what a flushed IF/ID register holds
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Memory-wait FSM of the hazard controller
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } mem_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : Tracks the multi-cycle mult/div unit. Qualifies the start
//                pulse and counts down the remaining latency; the unit runs
//                independently of pipeline freezes.
//  Ports       : clk, rst          - clock / async active-high reset
//                i_mdu_op          - ID instruction is mult/div
//                i_block           - start not allowed this cycle
//                o_mdu_start       - one-cycle operand-latch pulse
//                o_mdu_busy        - unit is computing
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mdu_op,
    input  logic i_block,
    output logic o_mdu_start,
    output logic o_mdu_busy
);

    localparam int CNT_W = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

    logic [CNT_W-1:0] r_mdu_cnt;

    assign o_mdu_busy  = (r_mdu_cnt != '0);
    assign o_mdu_start = i_mdu_op & ~o_mdu_busy & ~i_block;

    // Loaded with LATENCY-1 so busy drops exactly MDU_LATENCY cycles after
    // the start cycle; decrements regardless of pipeline state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdu_cnt <= '0;
        end else if (o_mdu_start) begin
            r_mdu_cnt <= CNT_W'(MDU_LATENCY - 1);
        end else if (o_mdu_busy) begin
            r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
        end
    end

endmodule : mdu_sequencer
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage MIPS pipeline.
//                Resolves load-use, EX redirect, data-memory wait and MDU
//                busy hazards; drives PC / pipeline-register enables and
//                flushes. Owns no datapath.
//  Ports       : clk, reset               - clock / async active-high reset
//                id_rs, id_rt, id_uses_rt - ID-stage source operands
//                id_mdu_op, id_mdu_read   - ID is mult/div, mfhi/mflo
//                ex_mem_read, ex_rt       - EX holds a load to ex_rt
//                ex_redirect              - EX taken branch/jump
//                mem_req, mem_ready       - data-memory handshake
//                pc_en .. mem_wb_bubble   - pipeline control
//                mdu_start, mdu_busy      - MDU control/status
//                mem_err                  - sticky memory timeout
//                stall_cycles             - saturating pc_en=0 counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_W       = MIPS_REG_W,
    parameter int MDU_LATENCY = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mdu_op,
    input  logic             id_mdu_read,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             mdu_start,
    output logic             mdu_busy,
    output logic             mem_err,
    output logic [31:0]      stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_err;
    logic              w_mem_err_nxt;
    logic [31:0]       r_stall_cycles;

    logic w_freeze;
    logic w_load_use;
    logic w_mdu_stall;
    logic w_mdu_block;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // Freeze takes effect in the very cycle the miss is first seen, before
    // the FSM has left RUN.
    assign w_freeze = ((r_state == ST_RUN)      & mem_req & ~mem_ready) |
                      ((r_state == ST_MEM_WAIT) & ~mem_ready)           |
                       (r_state == ST_ERROR);

    // $0 is hard-wired zero, so a load targeting it never creates a hazard
    assign w_load_use = ex_mem_read & (ex_rt != '0) &
                        ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign w_mdu_stall = mdu_busy & (id_mdu_op | id_mdu_read);

    assign w_mdu_block = reset | w_freeze | ex_redirect | w_load_use;

    // ------------------------------------------------------------------
    // MDU tracking
    // ------------------------------------------------------------------
    mdu_sequencer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_seq (
        .clk         (clk),
        .rst         (reset),
        .i_mdu_op    (id_mdu_op),
        .i_block     (w_mdu_block),
        .o_mdu_start (mdu_start),
        .o_mdu_busy  (mdu_busy)
    );

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (mem_req & ~mem_ready) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt   = ST_ERROR;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                // terminal until reset
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    assign mem_err = r_mem_err;

    // ------------------------------------------------------------------
    // Priority mux: reset > freeze > redirect > MDU stall > load-use
    // ------------------------------------------------------------------
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (w_freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_mdu_stall | w_load_use) begin
            // hold PC and IF/ID, inject one bubble into EX
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stall statistics (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (~pc_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Each scenario
//                drives a short stimulus list; expected control words are
//                queued on drive and compared at the following negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
    //  mem_wb_bubble, mdu_start}
    localparam logic [7:0] C_RUN   = 8'b1101_0100;
    localparam logic [7:0] C_START = 8'b1101_0101;
    localparam logic [7:0] C_STALL = 8'b0001_1100;
    localparam logic [7:0] C_FRZ   = 8'b0000_0010;
    localparam logic [7:0] C_REDIR = 8'b1111_1100;
    localparam logic [7:0] C_RST   = 8'b0010_1010;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       ld;
        logic [4:0] xrt;
        logic       op;
        logic       rd;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [7:0] ctrl;
        logic       busy;
        logic       err;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic        busy;
        logic        err;
        logic [31:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_mdu_op, id_mdu_read, ex_mem_read;
    logic        ex_redirect, mem_req, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_bubble, mdu_start, mdu_busy, mem_err;
    logic [31:0] stall_cycles;
    logic [7:0]  w_ctrl;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall;

    always #5 clk = ~clk;

    assign w_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                     ex_mem_en, mem_wb_bubble, mdu_start};

    pipeline_hazard_ctrl #(
        .REG_W       (5),
        .MDU_LATENCY (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_mdu_op     (id_mdu_op),
        .id_mdu_read   (id_mdu_read),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_bubble (mem_wb_bubble),
        .mdu_start     (mdu_start),
        .mdu_busy      (mdu_busy),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles)
    );

    function automatic stim_t mk(
        input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
        input logic ld, input logic [4:0] xrt, input logic op, input logic rd,
        input logic redir, input logic req, input logic rdy,
        input logic [7:0] ctrl, input logic busy, input logic err);
        stim_t s;
        s = '{rs, rt, uses_rt, ld, xrt, op, rd, redir, req, rdy, ctrl, busy, err};
        return s;
    endfunction

    // Applies one cycle of stimulus and queues its expected response; the
    // stall model counts every expected pc_en=0 cycle.
    task automatic drive(input stim_t s);
        exp_t e;
        id_rs       = s.rs;
        id_rt       = s.rt;
        id_uses_rt  = s.uses_rt;
        ex_mem_read = s.ld;
        ex_rt       = s.xrt;
        id_mdu_op   = s.op;
        id_mdu_read = s.rd;
        ex_redirect = s.redir;
        mem_req     = s.req;
        mem_ready   = s.rdy;
        e = '{s.ctrl, s.busy, s.err, exp_stall};
        sb.push_back(e);
        if (!s.ctrl[7] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
        id_mdu_op = 1'b0; id_mdu_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_stall = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (w_ctrl !== C_RST) begin n_fail++; $display("FAIL reset.ctrl: got %b, expected %b", w_ctrl, C_RST); end
        n_chk++;
        if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy: got %b, expected 0", mdu_busy); end
        n_chk++;
        if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset.err: got %b, expected 0", mem_err); end
        n_chk++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset.stall: got %0d, expected 0", stall_cycles); end
        reset = 1'b0;
        exp_stall = '0;
    endtask

    task automatic test_load_use();
        stim_t q[$];
        exp_t  e;
        do_reset();
        q.push_back(mk(2, 0, 0, 1, 2, 0, 0, 0, 0, 0, C_STALL, 0, 0)); // lw $2; add rs=$2
        q.push_back(mk(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, C_RUN,   0, 0)); // single bubble only
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0)); // load to $0
        q.push_back(mk(1, 5, 1, 1, 5, 0, 0, 0, 0, 0, C_STALL, 0, 0)); // rt match, rt used
        q.push_back(mk(1, 5, 0, 1, 5, 0, 0, 0, 0, 0, C_RUN,   0, 0)); // rt match, rt unused
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL load_use.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (stall_cycles !== e.stall) begin n_fail++; $display("FAIL load_use.stall step %0d: got %0d, expected %0d", i, stall_cycles, e.stall); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t q[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 3; k++)
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0, 0));   // ready: advance
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));   // stall count = 3
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL mem_wait.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (stall_cycles !== e.stall) begin n_fail++; $display("FAIL mem_wait.stall step %0d: got %0d, expected %0d", i, stall_cycles, e.stall); end
            n_chk++;
            if (mem_err !== e.err) begin n_fail++; $display("FAIL mem_wait.err step %0d: got %b, expected %b", i, mem_err, e.err); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mdu();
        stim_t q[$];
        exp_t  e;
        do_reset();
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_START, 0, 0)); // mult
        for (int k = 0; k < 3; k++)
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_STALL, 1, 0)); // mflo waits
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN,   0, 0)); // mflo issues
        // counter keeps running through a memory freeze
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_START, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_FRZ,   1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_FRZ,   1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, C_STALL, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_RUN,   0, 0));
        // back-to-back mult stalls without a second start
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_START, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STALL, 1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL mdu.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (mdu_busy !== e.busy) begin n_fail++; $display("FAIL mdu.busy step %0d: got %b, expected %b", i, mdu_busy, e.busy); end
            n_chk++;
            if (stall_cycles !== e.stall) begin n_fail++; $display("FAIL mdu.stall step %0d: got %0d, expected %0d", i, stall_cycles, e.stall); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        stim_t q[$];
        exp_t  e;
        do_reset();
        q.push_back(mk(2, 0, 0, 1, 2, 1, 0, 1, 0, 0, C_REDIR, 0, 0)); // beats load-use, no start
        q.push_back(mk(2, 0, 0, 1, 2, 1, 0, 0, 0, 0, C_STALL, 0, 0)); // load-use blocks start
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_START, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, C_REDIR, 1, 0)); // beats MDU stall
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ,   1, 0)); // freeze beats redirect
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN,   1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL redirect.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (mdu_busy !== e.busy) begin n_fail++; $display("FAIL redirect.busy step %0d: got %b, expected %b", i, mdu_busy, e.busy); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        stim_t q[$];
        exp_t  e;
        do_reset();
        for (int k = 0; k < 5; k++)                                     // RUN + 4 wait cycles
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 1));     // ERROR
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ, 0, 1));     // ready ignored
        q.push_back(mk(2, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_FRZ, 0, 1));     // still frozen
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL timeout.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (mem_err !== e.err) begin n_fail++; $display("FAIL timeout.err step %0d: got %b, expected %b", i, mem_err, e.err); end
            n_chk++;
            if (stall_cycles !== e.stall) begin n_fail++; $display("FAIL timeout.stall step %0d: got %0d, expected %0d", i, stall_cycles, e.stall); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        exp_t  e;
        do_reset();
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_START, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,   1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ,   1, 0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL reset_mid.ctrl step %0d: got %b, expected %b", i, w_ctrl, e.ctrl); end
            n_chk++;
            if (mdu_busy !== e.busy) begin n_fail++; $display("FAIL reset_mid.busy step %0d: got %b, expected %b", i, mdu_busy, e.busy); end
            @(posedge clk); #1;
        end
        // FSM now in MEM_WAIT with the MDU busy: reset takes effect without a clock
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid.async_busy: got %b, expected 0", mdu_busy); end
        n_chk++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_mid.async_stall: got %0d, expected 0", stall_cycles); end
        n_chk++;
        if (w_ctrl !== C_RST) begin n_fail++; $display("FAIL reset_mid.async_ctrl: got %b, expected %b", w_ctrl, C_RST); end
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        exp_stall = '0;
        // mem_ready low without a request only freezes if the FSM is still waiting
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (w_ctrl !== e.ctrl) begin n_fail++; $display("FAIL reset_mid.run_ctrl: got %b, expected %b", w_ctrl, e.ctrl); end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        exp_stall = '0;
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_mdu();
        test_redirect();
        test_timeout();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard.leftover: got %0d entries, expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
